// File: rtl/mult_div_pkg.sv
// Shared encodings and iteration-count helper for the iterative multiply/divide unit.
package mult_div_pkg;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   // Radix-2 datapath: one result bit retired per iteration cycle.
   localparam int unsigned BITS_PER_CYCLE = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } state_e;

   function automatic int unsigned iter_count(input int unsigned width);
      return width / BITS_PER_CYCLE;
   endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module mdu_cond_neg #(
   parameter int WIDTH = 32
) (
   input  logic             neg_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   assign data_o = neg_i ? (~data_i + WIDTH'(1)) : data_i;

endmodule

// File: rtl/mult_div_iter.sv
// Iterative radix-2 multiply / restoring divide unit with start/busy/done handshake.
// state | meaning
// IDLE  | waiting for start; divide-by-zero is answered here in one cycle
// MUL   | shift-add on magnitudes, one multiplier bit per cycle
// DIV   | restoring division on magnitudes, one quotient bit per cycle
// FIX   | apply result signs, load HI/LO, pulse done and write enables
module mult_div_iter
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic             signedn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             hi_write,
   output logic             lo_write,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned ITERS = iter_count(WIDTH);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             op_q, op_d;
   logic             signed_q, signed_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             wr_q, wr_d;
   logic             dz_q, dz_d;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic               res_neg, rem_neg;
   logic               last_iter;

   logic [WIDTH-1:0] mul_addend;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_sub;
   logic             div_ge;

   mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_a (
      .neg_i  (signedn & a[WIDTH-1]),
      .data_i (a),
      .data_o (mag_a)
   );

   mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_b (
      .neg_i  (signedn & b[WIDTH-1]),
      .data_i (b),
      .data_o (mag_b)
   );

   // Product is negated as one 2*WIDTH value; quotient and remainder carry separate signs.
   mdu_cond_neg #(.WIDTH(2*WIDTH)) u_neg_prod (
      .neg_i  (res_neg),
      .data_i ({acc_hi_q, acc_lo_q}),
      .data_o (prod_fix)
   );

   mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_quo (
      .neg_i  (res_neg),
      .data_i (acc_lo_q),
      .data_o (quo_fix)
   );

   mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_rem (
      .neg_i  (rem_neg),
      .data_i (acc_hi_q),
      .data_o (rem_fix)
   );

   assign res_neg   = signed_q & (sa_q ^ sb_q);
   assign rem_neg   = signed_q & sa_q;
   assign last_iter = (cnt_q == CNT_W'(ITERS - 1));

   assign mul_addend = acc_lo_q[0] ? opnd_q : '0;
   assign mul_sum    = {1'b0, acc_hi_q} + {1'b0, mul_addend};

   // Partial remainder stays below the divisor, so the low WIDTH bits of the difference suffice.
   assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, opnd_q});
   assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= OP_MUL;
         signed_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         opnd_q   <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         wr_q     <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         signed_q <= signed_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         opnd_q   <= opnd_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         wr_q     <= wr_d;
         dz_q     <= dz_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      signed_d = signed_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      opnd_d   = opnd_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      wr_d     = 1'b0;
      dz_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (op == OP_DIV && b == '0) begin
                  done_d = 1'b1;
                  dz_d   = 1'b1;
               end else begin
                  op_d     = op;
                  signed_d = signedn;
                  sa_d     = a[WIDTH-1];
                  sb_d     = b[WIDTH-1];
                  cnt_d    = '0;
                  busy_d   = 1'b1;
                  acc_hi_d = '0;
                  if (op == OP_DIV) begin
                     opnd_d   = mag_b;
                     acc_lo_d = mag_a;
                     state_d  = DIV;
                  end else begin
                     opnd_d   = mag_a;
                     acc_lo_d = mag_b;
                     state_d  = MUL;
                  end
               end
            end
         end

         MUL: begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_iter) state_d = FIX;
         end

         DIV: begin
            acc_hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_iter) state_d = FIX;
         end

         FIX: begin
            if (op_q == OP_MUL) begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
            done_d  = 1'b1;
            wr_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign hi_write = wr_q;
   assign lo_write = wr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_iter.sv
// Directed bench for mult_div_iter: behavioural result/timing model checked every cycle,
// plus literal expectations for each directed operation.
module tb_mult_div_iter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         op = 1'b0;
   logic         signedn = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] hi, lo;
   logic         hi_write, lo_write, busy, done, div_zero;

   always #5 clk = ~clk;

   mult_div_iter #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .signedn  (signedn),
      .a        (a),
      .b        (b),
      .hi       (hi),
      .lo       (lo),
      .hi_write (hi_write),
      .lo_write (lo_write),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit chk_en    = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
   endtask

   // Arithmetic reference: {hi, lo} for one operation, from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input logic o, input logic s,
                                         input logic [W-1:0] x, input logic [W-1:0] y);
      longint sx, sy;
      logic [63:0] r;
      if (!o) begin
         if (s) r = 64'(longint'($signed(x)) * longint'($signed(y)));
         else   r = {32'b0, x} * {32'b0, y};
      end else begin
         if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            r  = {32'(sx % sy), 32'(sx / sy)};
         end else begin
            r = {x % y, x / y};
         end
      end
      return r;
   endfunction

   // Observable behaviour: result appears WIDTH+1 edges after an accepted start.
   logic [W-1:0] m_hi = '0, m_lo = '0;
   logic         m_busy = 1'b0, m_done = 1'b0, m_wr = 1'b0, m_dz = 1'b0;
   logic [63:0]  m_pend = '0;
   int           m_rem = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0;
         m_wr = 1'b0; m_dz = 1'b0; m_rem = 0;
      end else begin
         m_done = 1'b0; m_wr = 1'b0; m_dz = 1'b0;
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               {m_hi, m_lo} = m_pend;
               m_done = 1'b1; m_wr = 1'b1; m_busy = 1'b0;
            end
         end else if (start) begin
            if (op && b == '0) begin
               m_done = 1'b1; m_dz = 1'b1;
            end else begin
               m_pend = model(op, signedn, a, b);
               m_rem  = W + 1;
               m_busy = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_busy",     64'(busy),     64'(m_busy));
         chk("cyc_done",     64'(done),     64'(m_done));
         chk("cyc_hi_write", 64'(hi_write), 64'(m_wr));
         chk("cyc_lo_write", 64'(lo_write), 64'(m_wr));
         chk("cyc_div_zero", 64'(div_zero), 64'(m_dz));
         chk("cyc_hi",       64'(hi),       64'(m_hi));
         chk("cyc_lo",       64'(lo),       64'(m_lo));
         chk("cyc_busy_done_excl", 64'(busy & done), 64'(0));
      end
   end

   // Called at a negedge; drives one start cycle then scrambles the operands.
   task automatic issue(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1; op = o; signedn = s; a = x; b = y;
      @(negedge clk);
      start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
   endtask

   task automatic wait_done(input string nm, input bit inj, input int exp_lat,
                            input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                            input logic exp_dz);
      int i = 0;
      while (done !== 1'b1 && i < 100) begin
         @(negedge clk);
         i++;
         if (inj) begin
            if (i == 5 || i == 20) begin
               start = 1'b1; op = 1'b0; signedn = 1'b0; a = 32'd3; b = 32'd3;
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      chk({nm, "_latency"}, 64'(i), 64'(exp_lat));
      chk({nm, "_hi"}, 64'(hi), 64'(exp_hi));
      chk({nm, "_lo"}, 64'(lo), 64'(exp_lo));
      chk({nm, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
      chk({nm, "_write"}, 64'(hi_write), 64'(!exp_dz));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_hi",       64'(hi),       64'(0));
      chk("rst_lo",       64'(lo),       64'(0));
      chk("rst_busy",     64'(busy),     64'(0));
      chk("rst_done",     64'(done),     64'(0));
      chk("rst_hi_write", 64'(hi_write), 64'(0));
      chk("rst_div_zero", 64'(div_zero), 64'(0));

      chk("model_pin_mul", model(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
      chk("model_pin_umul", model(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
      chk("model_pin_div", model(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
      chk("model_pin_min", model(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

      reset  = 1'b1;
      chk_en = 1'b1;

      @(negedge clk); issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5);
      wait_done("mul_s_m3x5", 1'b0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
      @(negedge clk); issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("mul_u_max", 1'b0, 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      @(negedge clk); issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("mul_s_m1xm1", 1'b0, 33, 32'h0, 32'h1, 1'b0);
      @(negedge clk); issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_done("div_s_m7d2", 1'b0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      @(negedge clk); issue(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE);
      wait_done("div_s_7dm2", 1'b0, 33, 32'h1, 32'hFFFF_FFFD, 1'b0);
      @(negedge clk); issue(1'b1, 1'b0, 32'd100, 32'd7);
      wait_done("div_u_100d7", 1'b0, 33, 32'd2, 32'd14, 1'b0);
      @(negedge clk); issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_s_min_m1", 1'b0, 33, 32'h0, 32'h8000_0000, 1'b0);
      @(negedge clk); issue(1'b1, 1'b0, 32'h451, 32'h20);
      wait_done("div_u_prep", 1'b0, 33, 32'h11, 32'h22, 1'b0);
      @(negedge clk); issue(1'b1, 1'b0, 32'd42, 32'd0);
      chk("div0_busy", 64'(busy), 64'(0));
      wait_done("div0", 1'b0, 0, 32'h11, 32'h22, 1'b1);

      @(negedge clk); issue(1'b0, 1'b0, 32'h1_0000, 32'h1_0000);
      wait_done("mul_ignore_start", 1'b1, 33, 32'h1, 32'h0, 1'b0);
      issue(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
      wait_done("mul_back_to_back", 1'b0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0);

      @(negedge clk); issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h10);
      repeat (9) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrst_busy",     64'(busy),     64'(0));
      chk("midrst_done",     64'(done),     64'(0));
      chk("midrst_hi",       64'(hi),       64'(0));
      chk("midrst_lo",       64'(lo),       64'(0));
      chk("midrst_lo_write", 64'(lo_write), 64'(0));
      chk("midrst_div_zero", 64'(div_zero), 64'(0));
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk); issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h10);
      wait_done("div_after_rst", 1'b0, 33, 32'hF, 32'h0FFF_FFFF, 1'b0);
      repeat (3) @(negedge clk);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mult_div_iter.md
Name: mult_div_iter

Overview:
Parametrised iterative multiply/divide unit for the multicycle CPU datapath. It succeeds the fixed 32-bit MultDiv block and adds several capabilities: width parameter, signed/unsigned mode, a start/busy/done handshake, deterministic latency, and a divide-by-zero flag. It is fed from the A/B register outputs and drives the HI/LO register inputs and write enables; the control unit sequences it.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits; must be >= 4.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-low
start  in  1  request operation; sampled only when busy=0
op  in  1  0=multiply, 1=divide
signedn  in  1  1=signed (two's complement), 0=unsigned
a  in  WIDTH  multiplicand / dividend
b  in  WIDTH  multiplier / divisor
hi  out  WIDTH  product upper half / remainder
lo  out  WIDTH  product lower half / quotient
hi_write  out  1  one-cycle pulse; HI register load enable
lo_write  out  1  one-cycle pulse; LO register load enable
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
div_zero  out  1  high with done when a divide had b==0

Behaviour:
- Reset values: hi=0, lo=0, busy=0, done=0, hi_write=0, lo_write=0, div_zero=0; FSM goes to IDLE and the counter is cleared. Reset asserted mid-operation aborts immediately and no done is produced.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE: start=1 at edge k performs these actions:
  - latch op and signedn;
  - latch operand magnitudes (negate a or b when signedn and its MSB is 1);
  - record result signs: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa;
  - clear the counter, set busy=1, and go to MUL or DIV.
- Divide with b==0 at edge k takes this path instead:
  - stay in IDLE;
  - done=1, div_zero=1 for the cycle after edge k;
  - hi/lo unchanged, hi_write=lo_write=0, busy stays 0.
- MUL: radix-2 shift-add on the 2*WIDTH accumulator, one bit per cycle, for WIDTH cycles, then go to FIX.
- DIV: restoring division, one quotient bit per cycle, for WIDTH cycles, then go to FIX.
- FIX (one cycle):
  - apply the recorded signs by conditional two's complement;
  - load hi/lo;
  - pulse done, hi_write, lo_write for exactly one cycle;
  - set busy=0 and div_zero=0;
  - return to IDLE.
- Latency: done is high in the cycle after edge k+WIDTH+1, i.e. WIDTH+1 edges after acceptance. busy is high from edge k until done rises; busy and done are never high together.
- start while busy=1 is ignored (no queueing). start in the same cycle as done is accepted normally, giving back-to-back operation.
- a and b are sampled only at acceptance; later changes have no effect.
- Arithmetic rules:
  - Multiply: {hi,lo} = full 2*WIDTH product, exact for both signed and unsigned.
  - Divide: quotient truncates toward zero; remainder takes the sign of the dividend; |rem| < |b|.
  - Signed MIN / -1: lo=MIN (0x80000000 at WIDTH=32), hi=0, no flag.
- hi/lo hold their values between operations.

Decomposition:
- Package mult_div_pkg holds:
  - op encodings (OP_MUL, OP_DIV);
  - state enum (IDLE, MUL, DIV, FIX);
  - a WIDTH-agnostic localparam for the iteration count.
- One sub-module, mdu_cond_neg (parametrised width, conditional two's-complement negate). It is instantiated for the operand magnitudes and for the result sign fix.

Test Plan:
- Signed mult, a=-3 (0xFFFFFFFD), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; done exactly 33 edges after acceptance; single hi_write/lo_write pulse.
- Unsigned mult, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Repeat with signedn=1 → hi=0, lo=1.
- Signed div -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Unsigned div 100/7 → lo=14, hi=2. Signed 0x80000000/-1 → lo=0x80000000, hi=0.
- Divide by zero, a=42, b=0, prior hi/lo=0x11/0x22:
  - done and div_zero are high for one cycle after acceptance;
  - hi/lo stay 0x11/0x22; busy is never set.
- Start pulsed at cycles 5 and 20 of a busy multiply with different operands → only the first result is produced. A start coincident with done → the second op completes WIDTH+1 edges later.
- reset driven low at cycle 10 of a divide → all outputs 0 immediately, with no done. A new op after reset release → correct result.
